instruction_fetch_unit: RTL

- Per-core fetch sequencer: the read-side initiator of the instruction memory port (one `addrN`/`instructionN` pair).
- Drives the 8-bit fetch address and consumes the instruction byte returned one cycle later by the registered memory.
- Resolves control-flow opcodes (JUMNZ with inline target byte, conditional END) locally.
- Hands all other opcodes to the core's execution unit over a valid/ready handshake.

---
 rtl/instruction_fetch_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: per-core fetch sequencer; resolves JUMNZ/END locally and
// hands every other opcode to the execution unit over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [7:0] OP_END   = 8'd38,
    parameter logic [7:0] OP_JUMNZ = 8'd40,
    parameter logic [7:0] START_PC = 8'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        z_flag,
    input  logic [7:0]  instruction,
    input  logic        exec_ready,
    output logic [7:0]  addr,
    output logic [7:0]  opcode,
    output logic        opcode_valid,
    output logic        busy,
    output logic        halted,
    output logic [15:0] issued_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, DISPATCH, OPER_FETCH, OPER_DECODE, HALT} state_t;
    state_t      state, state_nx;
    logic [7:0]  pc_nx, opcode_nx;
    logic        valid_nx;
    logic [15:0] count_nx;
    // The pc register is the fetch address itself, so addr always shows the pc.
    always_comb begin
        state_nx  = state;
        pc_nx     = addr;
        opcode_nx = opcode;
        valid_nx  = opcode_valid;
        count_nx  = issued_count;
        case (state)
            IDLE, HALT: if (start) begin
                state_nx = FETCH;
                pc_nx    = START_PC;
                count_nx = '0;
            end
            FETCH: state_nx = DECODE;
            DECODE: if (instruction == OP_JUMNZ) begin
                pc_nx    = addr + 8'd1;
                state_nx = OPER_FETCH;
            end else if (instruction == OP_END) begin
                pc_nx    = z_flag ? addr : addr + 8'd1;
                state_nx = z_flag ? HALT : FETCH;
            end else begin
                opcode_nx = instruction;
                valid_nx  = 1'b1;
                pc_nx     = addr + 8'd1;
                state_nx  = DISPATCH;
            end
            DISPATCH: if (exec_ready) begin
                valid_nx = 1'b0;
                count_nx = issued_count + 16'd1;
                state_nx = FETCH;
            end
            OPER_FETCH: state_nx = OPER_DECODE;
            OPER_DECODE: begin
                pc_nx    = z_flag ? addr + 8'd1 : instruction;
                state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr         <= '0;
            opcode       <= '0;
            opcode_valid <= 1'b0;
            issued_count <= '0;
        end else begin
            state        <= state_nx;
            addr         <= pc_nx;
            opcode       <= opcode_nx;
            opcode_valid <= valid_nx;
            issued_count <= count_nx;
        end
    end
    assign busy   = !(state == IDLE || state == HALT);
    assign halted = state == HALT;
endmodule
